// File: rtl/ceu_wr_fwd_pkg.sv
// Shared types, opcode/type constants and the opcode decoder for the CEU write forwarder.
package ceu_wr_fwd_pkg;

    localparam logic [11:0] CMD_MAP_ICM       = 12'hFFA;
    localparam logic [11:0] CMD_UNMAP_ICM     = 12'hFF9;
    localparam logic [11:0] CMD_SW2HW_MPT     = 12'h00D;
    localparam logic [11:0] CMD_HW2SW_MPT     = 12'h00F;
    localparam logic [11:0] CMD_WRITE_MTT     = 12'h011;
    localparam logic [11:0] CMD_SW2HW_EQ      = 12'h012;
    localparam logic [11:0] CMD_SW2HW_CQ      = 12'h016;
    localparam logic [11:0] CMD_RST2INIT_QPEE = 12'h019;

    localparam logic [7:0] ICM_TPT = 8'h01;
    localparam logic [7:0] MPT_TPT = 8'h02;
    localparam logic [7:0] MTT_TPT = 8'h03;
    localparam logic [7:0] CQ_TPT  = 8'h10;
    localparam logic [7:0] EQ_TPT  = 8'h11;
    localparam logic [7:0] QP_TPT  = 8'h12;

    localparam logic [7:0] WR_OPC_MAP     = 8'h01;
    localparam logic [7:0] WR_OPC_UNMAP   = 8'h02;
    localparam logic [7:0] WR_OPC_WRITE   = 8'h03;
    localparam logic [7:0] WR_OPC_INVALID = 8'h04;

    localparam int CH_V2P = 0;
    localparam int CH_CXT = 1;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_HDR     = 5'b00010,
        S_PAYLOAD = 5'b00100,
        S_BARE    = 5'b01000,
        S_DRAIN   = 5'b10000
    } wr_fwd_state_e;

    typedef struct packed {
        logic       known;
        logic [1:0] ch;
        logic [7:0] typ;
        logic [7:0] opcode;
        logic       hdr_skip;
        logic       low_from_param;
    } wr_fwd_dec_t;

    function automatic wr_fwd_dec_t wr_fwd_decode(input logic [11:0] op);
        wr_fwd_dec_t d;
        d = '0;
        d.known = 1'b1;
        d.ch    = 2'(CH_V2P);
        case (op)
            CMD_MAP_ICM:   begin d.typ = ICM_TPT; d.opcode = WR_OPC_MAP; end
            CMD_UNMAP_ICM: begin d.typ = ICM_TPT; d.opcode = WR_OPC_UNMAP; d.low_from_param = 1'b1; end
            CMD_SW2HW_MPT: begin d.typ = MPT_TPT; d.opcode = WR_OPC_WRITE; end
            CMD_HW2SW_MPT: begin d.typ = MPT_TPT; d.opcode = WR_OPC_INVALID; end
            CMD_WRITE_MTT: begin d.typ = MTT_TPT; d.opcode = WR_OPC_WRITE; d.hdr_skip = 1'b1; end
            CMD_SW2HW_CQ:      begin d.ch = 2'(CH_CXT); d.typ = CQ_TPT; d.opcode = WR_OPC_WRITE; end
            CMD_SW2HW_EQ:      begin d.ch = 2'(CH_CXT); d.typ = EQ_TPT; d.opcode = WR_OPC_WRITE; end
            CMD_RST2INIT_QPEE: begin d.ch = 2'(CH_CXT); d.typ = QP_TPT; d.opcode = WR_OPC_WRITE; end
            default:       d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ceu_wr_fwd_demux.sv
// Combinational steering of one valid/last/data/head stream onto NUM_CH flattened outputs.
module ceu_wr_fwd_demux
    import ceu_wr_fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int HEAD_WIDTH = 128,
    parameter int NUM_CH     = 2
) (
    input  logic                         i_en,
    input  logic [1:0]                   i_ch,
    input  logic                         i_valid,
    input  logic                         i_last,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic [HEAD_WIDTH-1:0]        i_head,
    input  logic [NUM_CH-1:0]            i_ready,
    output logic                         o_ready,
    output logic [NUM_CH-1:0]            o_valid,
    output logic [NUM_CH-1:0]            o_last,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic [NUM_CH*HEAD_WIDTH-1:0] o_head
);

    // Only the selected channel carries the stream; every other slice is held at zero
    always_comb begin
        o_ready = 1'b0;
        o_valid = '0;
        o_last  = '0;
        o_data  = '0;
        o_head  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_en && (int'(i_ch) == i)) begin
                o_valid[i]                         = i_valid;
                o_last[i]                          = i_last;
                o_data[i*DATA_WIDTH +: DATA_WIDTH] = i_data;
                o_head[i*HEAD_WIDTH +: HEAD_WIDTH] = i_head;
                o_ready                            = i_ready[i];
            end else begin
                o_valid[i] = 1'b0;
                o_last[i]  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ceu_wr_fwd.sv
// CEU write command forwarder: builds the request head and forwards head + inbox payload to one of NUM_CH streams.
// Defining WR_FWD_LEN_CHK_EN adds an inbox beat counter that flags length mismatches on err_len.
module ceu_wr_fwd
    import ceu_wr_fwd_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int DMA_HEAD_WIDTH = 128,
    parameter int HEAD_WIDTH     = 128,
    parameter int NUM_CH         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         finish,
    input  logic                         has_inbox,
    input  logic [11:0]                  op,
    input  logic [63:0]                  in_param,
    input  logic [31:0]                  in_modifier,
    input  logic                         dma_rd_rsp_valid,
    input  logic                         dma_rd_rsp_last,
    input  logic [DATA_WIDTH-1:0]        dma_rd_rsp_data,
    input  logic [DMA_HEAD_WIDTH-1:0]    dma_rd_rsp_head,
    output logic                         dma_rd_rsp_ready,
    output logic [NUM_CH-1:0]            fwd_valid,
    output logic [NUM_CH-1:0]            fwd_last,
    output logic [NUM_CH*DATA_WIDTH-1:0] fwd_data,
    output logic [NUM_CH*HEAD_WIDTH-1:0] fwd_head,
    input  logic [NUM_CH-1:0]            fwd_ready,
    output logic                         err_op,
    output logic                         err_len,
    output logic                         err_sticky
);

    wr_fwd_state_e         r_state;
    wr_fwd_dec_t           w_dec;
    logic [1:0]            r_ch;
    logic [7:0]            r_typ;
    logic [7:0]            r_opc;
    logic [31:0]           r_mod;
    logic [63:0]           r_lo;
    logic                  r_pend;
    logic                  r_sticky;
    logic                  w_known;
    logic                  w_accept;
    logic                  w_in_hs;
    logic                  w_drain_end;
    logic                  w_fin_fwd;
    logic                  w_sel_ready;
    logic                  w_en;
    logic                  w_s_valid;
    logic                  w_s_last;
    logic [DATA_WIDTH-1:0] w_s_data;
    logic [HEAD_WIDTH-1:0] w_head;
    logic                  w_len_err;

    assign w_dec       = wr_fwd_decode(op);
    // An opcode routed to a channel this instance does not build is treated as unknown
    assign w_known     = w_dec.known && (int'(w_dec.ch) < NUM_CH);
    assign w_accept    = (r_state == S_IDLE) && start && !r_pend;
    assign w_in_hs     = dma_rd_rsp_valid && dma_rd_rsp_ready;
    assign w_drain_end = (r_state == S_DRAIN) && dma_rd_rsp_valid && dma_rd_rsp_last;

    assign finish     = w_fin_fwd || w_drain_end || r_pend;
    assign err_op     = w_drain_end || r_pend;
    assign err_len    = w_len_err;
    assign err_sticky = r_sticky;

    // Downstream head: {typ, opcode, pad, modifier} over the 64-bit low word
    always_comb begin
        w_head        = '0;
        w_head[127:0] = {r_typ, r_opc, 16'h0000, r_mod, r_lo};
    end

    // Per-state stream selection, inbox back-pressure and forward-completion detect
    always_comb begin
        w_en             = 1'b0;
        w_s_valid        = 1'b0;
        w_s_last         = 1'b0;
        w_s_data         = '0;
        dma_rd_rsp_ready = 1'b0;
        w_fin_fwd        = 1'b0;
        case (r_state)
            S_HDR:   dma_rd_rsp_ready = 1'b1;
            S_DRAIN: dma_rd_rsp_ready = 1'b1;
            S_PAYLOAD: begin
                w_en             = 1'b1;
                w_s_valid        = dma_rd_rsp_valid;
                w_s_last         = dma_rd_rsp_last;
                w_s_data         = dma_rd_rsp_data;
                dma_rd_rsp_ready = w_sel_ready;
                w_fin_fwd        = dma_rd_rsp_valid && dma_rd_rsp_last && w_sel_ready;
            end
            S_BARE: begin
                w_en      = 1'b1;
                w_s_valid = 1'b1;
                w_s_last  = 1'b1;
                w_fin_fwd = w_sel_ready;
            end
            default: w_en = 1'b0;
        endcase
    end

    // Command capture and state sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ch    <= 2'd0;
            r_typ   <= 8'd0;
            r_opc   <= 8'd0;
            r_mod   <= 32'd0;
            r_lo    <= 64'd0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= w_accept && !w_known && !has_inbox;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ch  <= w_dec.ch;
                        r_typ <= w_dec.typ;
                        r_opc <= w_dec.opcode;
                        r_mod <= in_modifier;
                        r_lo  <= w_dec.low_from_param ? in_param : 64'd0;
                        if (!w_known)               r_state <= has_inbox ? S_DRAIN : S_IDLE;
                        else if (!has_inbox)        r_state <= S_BARE;
                        else if (w_dec.hdr_skip)    r_state <= S_HDR;
                        else                        r_state <= S_PAYLOAD;
                    end
                end
                S_HDR: begin
                    if (w_in_hs) begin
                        r_lo    <= dma_rd_rsp_data[63:0];
                        r_state <= dma_rd_rsp_last ? S_BARE : S_PAYLOAD;
                    end
                end
                S_PAYLOAD, S_BARE: if (w_fin_fwd) r_state <= S_IDLE;
                S_DRAIN:           if (w_drain_end) r_state <= S_IDLE;
                default:           r_state <= S_IDLE;
            endcase
        end
    end

    // Error history, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) r_sticky <= 1'b0;
        else        r_sticky <= r_sticky || err_op || err_len;
    end

`ifdef WR_FWD_LEN_CHK_EN
    localparam int BPB = DATA_WIDTH / 8;
    logic [12:0] r_cnt;
    logic [12:0] r_exp;
    logic [13:0] w_len_round;
    logic [12:0] w_exp_now;
    logic        w_unused_head;

    assign w_unused_head = ^dma_rd_rsp_head[DMA_HEAD_WIDTH-1:13];
    assign w_len_round   = {1'b0, dma_rd_rsp_head[12:0]} + 14'(BPB - 1);
    assign w_exp_now     = 13'(w_len_round / 14'(BPB));
    assign w_len_err     = w_in_hs && dma_rd_rsp_last &&
                           ((r_cnt + 13'd1) != ((r_cnt == 13'd0) ? w_exp_now : r_exp));

    // Inbox beat counter; expected count is latched from the head of the first beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 13'd0;
            r_exp <= 13'd0;
        end else if (w_in_hs) begin
            if (dma_rd_rsp_last) begin
                r_cnt <= 13'd0;
            end else begin
                r_cnt <= r_cnt + 13'd1;
                if (r_cnt == 13'd0) r_exp <= w_exp_now;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end
`else
    logic w_unused_head;
    assign w_unused_head = ^dma_rd_rsp_head;
    assign w_len_err     = 1'b0;
`endif

    ceu_wr_fwd_demux #(
        .DATA_WIDTH (DATA_WIDTH),
        .HEAD_WIDTH (HEAD_WIDTH),
        .NUM_CH     (NUM_CH)
    ) u_demux (
        .i_en    (w_en),
        .i_ch    (r_ch),
        .i_valid (w_s_valid),
        .i_last  (w_s_last),
        .i_data  (w_s_data),
        .i_head  (w_head),
        .i_ready (fwd_ready),
        .o_ready (w_sel_ready),
        .o_valid (fwd_valid),
        .o_last  (fwd_last),
        .o_data  (fwd_data),
        .o_head  (fwd_head)
    );

endmodule

// File: tb/tb_ceu_wr_fwd.sv
// Self-checking bench for ceu_wr_fwd: directed scenarios plus randomized commands against a beat-list reference model.
module tb_ceu_wr_fwd;

    localparam int DW = 256;
    localparam int HW = 128;
    localparam int NCH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            finish;
    logic            has_inbox = 1'b0;
    logic [11:0]     op = 12'd0;
    logic [63:0]     in_param = 64'd0;
    logic [31:0]     in_modifier = 32'd0;
    logic            dma_valid = 1'b0;
    logic            dma_last = 1'b0;
    logic [DW-1:0]   dma_data = '0;
    logic [127:0]    dma_head = '0;
    logic            dma_ready;
    logic [NCH-1:0]  fwd_valid;
    logic [NCH-1:0]  fwd_last;
    logic [NCH*DW-1:0] fwd_data;
    logic [NCH*HW-1:0] fwd_head;
    logic [NCH-1:0]  fwd_ready = '0;
    logic            err_op;
    logic            err_len;
    logic            err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Beats offered by the DMA source and observations of one command
    logic [DW-1:0] tx_beats [8];
    logic [DW-1:0] o_data [$];
    logic          o_last [$];
    logic [HW-1:0] o_head [$];
    int            o_ch [$];
    int  o_fin_cyc, o_first_valid, o_vcycles, o_consumed;
    bit  o_err_op, o_err_len, o_err_len_fin, o_timeout, o_post;
    bit  o_vseen [NCH];

    always #5 clk = ~clk;

    ceu_wr_fwd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .finish           (finish),
        .has_inbox        (has_inbox),
        .op               (op),
        .in_param         (in_param),
        .in_modifier      (in_modifier),
        .dma_rd_rsp_valid (dma_valid),
        .dma_rd_rsp_last  (dma_last),
        .dma_rd_rsp_data  (dma_data),
        .dma_rd_rsp_head  (dma_head),
        .dma_rd_rsp_ready (dma_ready),
        .fwd_valid        (fwd_valid),
        .fwd_last         (fwd_last),
        .fwd_data         (fwd_data),
        .fwd_head         (fwd_head),
        .fwd_ready        (fwd_ready),
        .err_op           (err_op),
        .err_len          (err_len),
        .err_sticky       (err_sticky)
    );

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference opcode table: known, channel, type, opcode, header-skip, low-from-param
    task automatic ref_lookup(input logic [11:0] c, output bit known, output int ch,
                              output logic [7:0] typ, output logic [7:0] opc, output bit skip, output bit lfp);
        known = 1; ch = 0; skip = 0; lfp = 0; typ = 8'h00; opc = 8'h00;
        case (c)
            12'hFFA: begin typ = 8'h01; opc = 8'h01; end
            12'hFF9: begin typ = 8'h01; opc = 8'h02; lfp = 1; end
            12'h00D: begin typ = 8'h02; opc = 8'h03; end
            12'h00F: begin typ = 8'h02; opc = 8'h04; end
            12'h011: begin typ = 8'h03; opc = 8'h03; skip = 1; end
            12'h016: begin ch = 1; typ = 8'h10; opc = 8'h03; end
            12'h012: begin ch = 1; typ = 8'h11; opc = 8'h03; end
            12'h019: begin ch = 1; typ = 8'h12; opc = 8'h03; end
            default: known = 0;
        endcase
    endtask

    // Drives one command; rmode 0 ready, 1 random, 2 toggling, 3 stalled for cycles 0..3
    task automatic run_cmd(input logic [11:0] c, input bit inbox, input logic [63:0] par,
                           input logic [31:0] mdf, input int nb, input logic [12:0] len,
                           input int rmode, input bit vgap);
        int  idx;
        bit  done, hs;
        o_data.delete(); o_last.delete(); o_head.delete(); o_ch.delete();
        o_fin_cyc = -1; o_first_valid = -1; o_vcycles = 0; o_err_op = 0; o_err_len = 0;
        o_err_len_fin = 0; o_timeout = 0; o_post = 0;
        for (int k = 0; k < NCH; k++) o_vseen[k] = 0;
        idx = 0; done = 0;
        @(posedge clk); #1;
        start = 1'b1; op = c; has_inbox = inbox; in_param = par; in_modifier = mdf;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (inbox && idx < nb && (!vgap || $urandom_range(0, 3) != 0)) begin
                dma_valid = 1'b1; dma_data = tx_beats[idx]; dma_last = (idx == nb - 1);
                dma_head = {115'd0, len};
            end else begin
                dma_valid = 1'b0; dma_last = 1'b0;
            end
            case (rmode)
                0:       fwd_ready = '1;
                1:       fwd_ready = NCH'($urandom_range(0, 3));
                2:       fwd_ready = (cyc % 2 == 1) ? '1 : '0;
                default: fwd_ready = (cyc < 4) ? '0 : '1;
            endcase
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (fwd_valid[k]) begin
                    o_vseen[k] = 1;
                    o_vcycles++;
                    if (o_first_valid < 0) o_first_valid = cyc;
                    if (fwd_ready[k]) begin
                        o_data.push_back(fwd_data[k*DW +: DW]);
                        o_last.push_back(fwd_last[k]);
                        o_head.push_back(fwd_head[k*HW +: HW]);
                        o_ch.push_back(k);
                    end
                end
            end
            if (err_op) o_err_op = 1;
            if (err_len) o_err_len = 1;
            if (finish) begin
                done = 1; o_fin_cyc = cyc;
                if (err_len) o_err_len_fin = 1;
            end
            hs = dma_valid && dma_ready;
            @(posedge clk); #1;
            if (hs) idx++;
        end
        o_timeout = !done;
        o_consumed = idx;
        start = 1'b0; dma_valid = 1'b0; dma_last = 1'b0; fwd_ready = '1;
        @(negedge clk);
        if (finish || (|fwd_valid) || dma_ready) o_post = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({finish, dma_ready, fwd_valid, fwd_last, err_op, err_len, err_sticky} !== '0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b required 0", {finish, dma_ready, fwd_valid, fwd_last, err_op, err_len, err_sticky});
        end
        n_checks++;
        if ((fwd_data !== '0) || (fwd_head !== '0)) begin
            n_errors++;
            $display("FAIL reset_data: data/head not 0 (data=%h)", fwd_data[63:0]);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_write_mtt();
        logic [HW-1:0] exp_h;
        tx_beats[0] = rnd_beat(); tx_beats[0][63:0] = 64'h1000;
        tx_beats[1] = rnd_beat();
        run_cmd(12'h011, 1, 64'h5555, 32'd4, 2, 13'd64, 0, 0);
        exp_h = {8'h03, 8'h03, 16'h0, 32'd4, 64'h1000};
        n_checks++;
        if (o_timeout || o_data.size() != 1) begin
            n_errors++; $display("FAIL mtt_beats: got %0d beats (timeout=%0d) required 1", o_data.size(), o_timeout);
        end else begin
            n_checks++;
            if (o_data[0] !== tx_beats[1] || o_last[0] !== 1'b1 || o_ch[0] != 0) begin
                n_errors++; $display("FAIL mtt_beat: data=%h last=%b ch=%0d", o_data[0][63:0], o_last[0], o_ch[0]);
            end
            n_checks++;
            if (o_head[0] !== exp_h) begin
                n_errors++; $display("FAIL mtt_head: got %h required %h", o_head[0], exp_h);
            end
        end
        n_checks++;
        if (o_fin_cyc != 2 || o_first_valid != 2) begin
            n_errors++; $display("FAIL mtt_latency: finish cyc %0d first valid %0d required 2/2", o_fin_cyc, o_first_valid);
        end
    endtask

    task automatic test_bare_stall();
        logic [HW-1:0] exp_h;
        run_cmd(12'hFF9, 0, 64'hABCD_0000, 32'h77, 0, 13'd0, 3, 0);
        exp_h = {8'h01, 8'h02, 16'h0, 32'h77, 64'hABCD_0000};
        n_checks++;
        if (o_fin_cyc != 4 || o_vcycles != 4 || o_first_valid != 1) begin
            n_errors++; $display("FAIL bare_stall: fin %0d valid cycles %0d first %0d required 4/4/1", o_fin_cyc, o_vcycles, o_first_valid);
        end
        n_checks++;
        if (o_data.size() != 1 || o_data[0] !== '0 || o_head[0] !== exp_h || o_last[0] !== 1'b1) begin
            n_errors++; $display("FAIL bare_beat: beats %0d head %h required %h", o_data.size(), (o_head.size() > 0) ? o_head[0] : '0, exp_h);
        end
    endtask

    task automatic test_cxt_toggle();
        bit bad;
        for (int k = 0; k < 4; k++) tx_beats[k] = rnd_beat();
        run_cmd(12'h016, 1, 64'h9, 32'h12, 4, 13'd128, 2, 0);
        bad = (o_data.size() != 4);
        for (int k = 0; k < o_data.size() && k < 4; k++)
            if (o_data[k] !== tx_beats[k] || o_last[k] !== (k == 3) || o_ch[k] != 1) bad = 1;
        n_checks++;
        if (bad) begin
            n_errors++; $display("FAIL cxt_order: got %0d beats required 4 in order on ch1", o_data.size());
        end
        n_checks++;
        if (o_vseen[0]) begin
            n_errors++; $display("FAIL cxt_ch0_quiet: fwd_valid[0] seen 1 required 0");
        end
    endtask

    task automatic test_unknown_drain();
        for (int k = 0; k < 3; k++) tx_beats[k] = rnd_beat();
        run_cmd(12'hFFF, 1, 64'h0, 32'h0, 3, 13'd96, 0, 0);
        n_checks++;
        if (o_vseen[0] || o_vseen[1] || o_consumed != 3) begin
            n_errors++; $display("FAIL drain_fwd: consumed %0d forwarded-valid %0d%0d required 3/00", o_consumed, o_vseen[1], o_vseen[0]);
        end
        n_checks++;
        if (o_fin_cyc != 3 || !o_err_op) begin
            n_errors++; $display("FAIL drain_finish: finish cyc %0d err_op %0d required 3/1", o_fin_cyc, o_err_op);
        end
        n_checks++;
        if (err_sticky !== 1'b1) begin
            n_errors++; $display("FAIL drain_sticky: got %b required 1", err_sticky);
        end
    endtask

    task automatic test_len_check();
        bit exp_err;
`ifdef WR_FWD_LEN_CHK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        for (int k = 0; k < 2; k++) tx_beats[k] = rnd_beat();
        run_cmd(12'h00D, 1, 64'h0, 32'h3, 2, 13'd96, 0, 0);
        n_checks++;
        if (o_err_len_fin != exp_err || o_err_len != exp_err) begin
            n_errors++; $display("FAIL len96: err_len %0d with finish %0d required %0d", o_err_len, o_err_len_fin, exp_err);
        end
        run_cmd(12'h00D, 1, 64'h0, 32'h3, 2, 13'd64, 0, 0);
        n_checks++;
        if (o_err_len) begin
            n_errors++; $display("FAIL len64: err_len got 1 required 0");
        end
    endtask

    task automatic test_reset_mid();
        bit pre_valid;
        for (int k = 0; k < 4; k++) tx_beats[k] = rnd_beat();
        @(posedge clk); #1;
        start = 1'b1; op = 12'h00D; has_inbox = 1'b1; fwd_ready = '1;
        dma_valid = 1'b1; dma_data = tx_beats[0]; dma_last = 1'b0; dma_head = 128'd128;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dma_data = tx_beats[1]; rst_n = 1'b0;
        @(negedge clk);
        pre_valid = fwd_valid[0];
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; dma_data = tx_beats[2];
        @(negedge clk);
        n_checks++;
        if (!pre_valid || {finish, dma_ready, fwd_valid, fwd_last, err_op, err_len, err_sticky} !== '0 || fwd_data !== '0 || fwd_head !== '0) begin
            n_errors++; $display("FAIL mid_reset: pre-valid %0d ctrl %b required 1/0", pre_valid,
                                 {finish, dma_ready, fwd_valid, fwd_last, err_op, err_len, err_sticky});
        end
        dma_valid = 1'b0;
        run_cmd(12'h00F, 0, 64'h1, 32'h42, 0, 13'd0, 0, 0);
        n_checks++;
        if (o_fin_cyc != 1 || o_data.size() != 1 || o_head[0] !== {8'h02, 8'h04, 16'h0, 32'h42, 64'h0}) begin
            n_errors++; $display("FAIL post_reset_bare: finish cyc %0d beats %0d required 1/1", o_fin_cyc, o_data.size());
        end
    endtask

    task automatic test_random();
        logic [11:0]   ops [10] = '{12'hFFA, 12'hFF9, 12'h00D, 12'h00F, 12'h011, 12'h016, 12'h012, 12'h019, 12'hFFF, 12'h7FF};
        logic [11:0]   c;
        logic [63:0]   par, lo;
        logic [31:0]   mdf;
        logic [12:0]   len;
        logic [7:0]    typ, opc;
        logic [DW-1:0] exp_q [$];
        logic [HW-1:0] exp_h;
        bit            inbox, known, skip, lfp, bad, exp_len_err;
        int            nb, ch;
        for (int n = 0; n < 30; n++) begin
            c = ops[$urandom_range(0, 9)];
            inbox = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 5);
            len = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 200)) : 13'(nb * 32 - $urandom_range(0, 31));
            par = {$urandom, $urandom}; mdf = $urandom;
            for (int k = 0; k < 8; k++) tx_beats[k] = rnd_beat();
            run_cmd(c, inbox, par, mdf, nb, len, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            ref_lookup(c, known, ch, typ, opc, skip, lfp);
            exp_q.delete();
            lo = lfp ? par : 64'd0;
            if (known && !inbox) exp_q.push_back('0);
            else if (known && skip) begin
                lo = tx_beats[0][63:0];
                if (nb == 1) exp_q.push_back('0);
                for (int k = 1; k < nb; k++) exp_q.push_back(tx_beats[k]);
            end else if (known) begin
                for (int k = 0; k < nb; k++) exp_q.push_back(tx_beats[k]);
            end
            exp_h = {typ, opc, 16'h0, mdf, lo};
            bad = o_timeout || (o_data.size() != exp_q.size());
            for (int k = 0; k < o_data.size() && k < exp_q.size(); k++)
                if (o_data[k] !== exp_q[k] || o_last[k] !== (k == exp_q.size() - 1) || o_head[k] !== exp_h || o_ch[k] != ch) bad = 1;
            n_checks++;
            if (bad) begin
                n_errors++; $display("FAIL rnd_fwd[%0d]: op %h got %0d beats required %0d", n, c, o_data.size(), exp_q.size());
            end
            n_checks++;
            if (o_err_op != !known || o_consumed != (inbox ? nb : 0) || o_post || o_vseen[1 - ch]) begin
                n_errors++; $display("FAIL rnd_ctl[%0d]: op %h err_op %0d consumed %0d post %0d", n, c, o_err_op, o_consumed, o_post);
            end
`ifdef WR_FWD_LEN_CHK_EN
            exp_len_err = inbox && (((int'(len) + 31) / 32) != nb);
`else
            exp_len_err = 0;
`endif
            n_checks++;
            if (o_err_len != exp_len_err) begin
                n_errors++; $display("FAIL rnd_len[%0d]: err_len %0d required %0d (len %0d beats %0d)", n, o_err_len, exp_len_err, len, nb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_mtt();
        test_bare_stall();
        test_cxt_toggle();
        test_unknown_drain();
        test_len_check();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
